dot_product_engine: RTL and testbench



---
 rtl/dp_pkg.sv | 16 +
 rtl/dp_lane_mul.sv | 38 +++
 rtl/dot_product_engine.sv | 188 ++++++++++++++++++
 tb/tb_dot_product_engine.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared types and pipeline depth constants for the dot-product engine.
// Imported by the engine top and its per-lane multiplier.
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dp_state_t;

    // memory read latency, then one product register stage
    localparam int RD_LAT    = 1;
    localparam int DRAIN_CYC = RD_LAT + 1;

endpackage

// File: rtl/dp_lane_mul.sv
// One multiply lane: zero-extends the pixel, sign- or zero-extends the
// weight and registers the full-precision signed product.
module dp_lane_mul
    import dp_pkg::*;
#(
    parameter  int PIX_W = 8,
    parameter  int WT_W  = 16,
    localparam int P_W   = PIX_W + WT_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_signed,
    input  logic [PIX_W-1:0]      i_pix,
    input  logic [WT_W-1:0]       i_wt,
    output logic signed [P_W-1:0] o_prod
);

    logic signed [P_W-1:0] w_pe;
    logic signed [P_W-1:0] w_we;
    logic signed [P_W-1:0] w_prod;
    logic signed [P_W-1:0] r_prod;

    assign w_pe   = {{(WT_W+1){1'b0}}, i_pix};
    assign w_we   = {{(PIX_W+1){i_signed & i_wt[WT_W-1]}}, i_wt};
    assign w_prod = w_pe * w_we;

    // product register; idle lanes contribute zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_prod <= '0;
        else
            r_prod <= i_en ? w_prod : '0;
    end

    assign o_prod = r_prod;

endmodule

// File: rtl/dot_product_engine.sv
// Multi-lane MAC engine: streams one weight row against the pixel
// vector and converts the wide accumulator to a saturating/wrapping result.
module dot_product_engine
    import dp_pkg::*;
#(
    parameter  int LANES    = 2,
    parameter  int VEC_LEN  = 784,
    parameter  int ROWS     = 10,
    parameter  int PIX_W    = 8,
    parameter  int WT_W     = 16,
    parameter  int OUT_W    = 16,
    parameter  int PIX_BASE = 0,
    parameter  int WT_BASE  = 0,
    localparam int BEATS    = VEC_LEN / LANES,
    localparam int PA_W     = $clog2(PIX_BASE + VEC_LEN),
    localparam int WA_W     = $clog2(WT_BASE + ROWS * VEC_LEN),
    localparam int RS_W     = $clog2(ROWS),
    localparam int ACC_W    = PIX_W + WT_W + $clog2(VEC_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [RS_W-1:0]       row_select,
    input  logic                  signed_mode,
    input  logic                  saturate,
    input  logic                  abort,
    input  logic [LANES*PIX_W-1:0] pixel_data,
    input  logic [LANES*WT_W-1:0] weight_data,
    output logic [LANES*PA_W-1:0] pixel_addr,
    output logic [LANES*WA_W-1:0] weight_addr,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      result,
    output logic                  overflow,
    output logic                  err
);

    localparam int P_W = PIX_W + WT_W + 1;
    localparam int KW  = $clog2(BEATS + 1);

    localparam logic signed [ACC_W-1:0] C_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] C_SMAX = (C_ONE <<< (OUT_W-1)) - C_ONE;
    localparam logic signed [ACC_W-1:0] C_SMIN = -(C_ONE <<< (OUT_W-1));
    localparam logic signed [ACC_W-1:0] C_UMAX = (C_ONE <<< OUT_W) - C_ONE;

    dp_state_t               r_state;
    logic [KW-1:0]           r_k;
    logic [RS_W-1:0]         r_row;
    logic                    r_sgn;
    logic                    r_sat;
    logic                    r_dvalid;
    logic                    r_err;
    logic                    r_ovf;
    logic [OUT_W-1:0]        r_result;
    logic signed [ACC_W-1:0] r_acc;

    logic signed [P_W-1:0]   w_prod [LANES];
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_final;
    logic [OUT_W-1:0]        w_res;
    logic                    w_ovf;
    logic                    w_issue;
    logic                    w_row_ok;

    assign w_issue  = (r_state == ISSUE);
    assign w_row_ok = int'(row_select) < ROWS;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dp_lane_mul #(
            .PIX_W (PIX_W),
            .WT_W  (WT_W)
        ) u_mul (
            .clk      (clk),
            .rst      (rst),
            .i_en     (r_dvalid),
            .i_signed (r_sgn),
            .i_pix    (pixel_data[i*PIX_W +: PIX_W]),
            .i_wt     (weight_data[i*WT_W +: WT_W]),
            .o_prod   (w_prod[i])
        );

        assign pixel_addr[i*PA_W +: PA_W] = w_issue
            ? PA_W'(PIX_BASE + int'(r_k) * LANES + i)
            : PA_W'(PIX_BASE + i);

        assign weight_addr[i*WA_W +: WA_W] = w_issue
            ? WA_W'(WT_BASE + int'(r_row) * VEC_LEN + int'(r_k) * LANES + i)
            : WA_W'(WT_BASE + i);
    end

    // sum of this cycle's lane products, sign-extended to the accumulator
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++)
            w_sum = w_sum + {{(ACC_W-P_W){w_prod[i][P_W-1]}}, w_prod[i]};
    end

    assign w_final = r_acc + w_sum;

    // range check against the signed or unsigned output window
    always_comb begin
        w_ovf = 1'b0;
        w_res = w_final[OUT_W-1:0];
        if (r_sgn) begin
            if (w_final > C_SMAX) begin
                w_ovf = 1'b1;
                if (r_sat) w_res = C_SMAX[OUT_W-1:0];
            end else if (w_final < C_SMIN) begin
                w_ovf = 1'b1;
                if (r_sat) w_res = C_SMIN[OUT_W-1:0];
            end
        end else begin
            if (w_final[ACC_W-1]) begin
                w_ovf = 1'b1;
                if (r_sat) w_res = '0;
            end else if (w_final > C_UMAX) begin
                w_ovf = 1'b1;
                if (r_sat) w_res = C_UMAX[OUT_W-1:0];
            end
        end
    end

    // control FSM, beat counter, accumulator and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_row    <= '0;
            r_sgn    <= 1'b0;
            r_sat    <= 1'b0;
            r_dvalid <= 1'b0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_acc    <= '0;
        end else begin
            r_err    <= 1'b0;
            r_dvalid <= w_issue && !abort;
            if (abort) begin
                r_state <= IDLE;
                r_k     <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (start && w_row_ok) begin
                            r_row   <= row_select;
                            r_sgn   <= signed_mode;
                            r_sat   <= saturate;
                            r_acc   <= '0;
                            r_k     <= '0;
                            r_state <= ISSUE;
                        end else if (start) begin
                            r_err <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        r_acc <= w_final;
                        if (r_k == KW'(BEATS-1)) begin
                            r_k     <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                    DRAIN: begin
                        r_acc <= w_final;
                        if (r_k == KW'(DRAIN_CYC-1)) begin
                            r_k      <= '0;
                            r_result <= w_res;
                            r_ovf    <= w_ovf;
                            r_state  <= DONE;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                    DONE: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy     = (r_state == ISSUE) || (r_state == DRAIN);
    assign done     = (r_state == DONE);
    assign result   = r_result;
    assign overflow = r_ovf;
    assign err      = r_err;

endmodule

// File: tb/tb_dot_product_engine.sv
// Randomised bench for dot_product_engine with a transaction-level
// reference model and per-cycle output comparison.
module tb_dot_product_engine;

    localparam int L     = 2;
    localparam int VL    = 784;
    localparam int NR    = 10;
    localparam int BEATS = VL / L;
    localparam int PA_W  = $clog2(VL);
    localparam int WA_W  = $clog2(NR * VL);
    localparam int RS_W  = $clog2(NR);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start4 = 1'b0;
    logic [RS_W-1:0] row_select = '0;
    logic signed_mode = 1'b0;
    logic saturate = 1'b0;
    logic abort = 1'b0;

    logic [L*8-1:0]     pixel_data;
    logic [L*16-1:0]    weight_data;
    logic [L*PA_W-1:0]  pixel_addr;
    logic [L*WA_W-1:0]  weight_addr;
    logic               busy, done, err, overflow;
    logic [15:0]        result;

    logic [4*8-1:0]     pd4;
    logic [4*16-1:0]    wd4;
    logic [4*PA_W-1:0]  pa4;
    logic [4*WA_W-1:0]  wa4;
    logic               busy4, done4, err4, ovf4;
    logic [15:0]        res4;

    logic [7:0]  pix_mem [VL];
    logic [15:0] wt_mem  [NR*VL];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0 = 0;
    int n_done4 = 0;

    dot_product_engine dut (
        .clk(clk), .rst(rst), .start(start), .row_select(row_select),
        .signed_mode(signed_mode), .saturate(saturate), .abort(abort),
        .pixel_data(pixel_data), .weight_data(weight_data),
        .pixel_addr(pixel_addr), .weight_addr(weight_addr),
        .busy(busy), .done(done), .result(result),
        .overflow(overflow), .err(err)
    );

    dot_product_engine #(.LANES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .row_select(row_select),
        .signed_mode(signed_mode), .saturate(saturate), .abort(1'b0),
        .pixel_data(pd4), .weight_data(wd4),
        .pixel_addr(pa4), .weight_addr(wa4),
        .busy(busy4), .done(done4), .result(res4),
        .overflow(ovf4), .err(err4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read memories, one cycle latency
    always @(posedge clk) begin
        for (int i = 0; i < L; i++) begin
            pixel_data[i*8 +: 8]    <= pix_mem[pixel_addr[i*PA_W +: PA_W]];
            weight_data[i*16 +: 16] <= wt_mem[weight_addr[i*WA_W +: WA_W]];
        end
        for (int i = 0; i < 4; i++) begin
            pd4[i*8 +: 8]   <= pix_mem[pa4[i*PA_W +: PA_W]];
            wd4[i*16 +: 16] <= wt_mem[wa4[i*WA_W +: WA_W]];
        end
    end

    always @(negedge clk) if (done4 === 1'b1) n_done4++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // plain-arithmetic dot product with output conversion
    function automatic void ref_dot(input int row, input bit sgn,
                                    input bit sat, output logic [15:0] r,
                                    output bit o);
        longint v, w, lo, hi;
        v = 0;
        for (int j = 0; j < VL; j++) begin
            w = longint'(wt_mem[row*VL + j]);
            if (sgn && w >= 32768) w = w - 65536;
            v = v + longint'(pix_mem[j]) * w;
        end
        lo = sgn ? -32768 : 0;
        hi = sgn ? 32767 : 65535;
        o = 1'b0;
        r = v[15:0];
        if (v > hi) begin
            o = 1'b1;
            if (sat) r = hi[15:0];
        end else if (v < lo) begin
            o = 1'b1;
            if (sat) r = lo[15:0];
        end
    endfunction

    // transaction model: cycles since acceptance, 0 when idle
    int          m_cnt;
    int          m_row;
    logic        m_err;
    logic [15:0] m_res, m_pres;
    logic        m_ovf, m_povf;
    logic [15:0] t_r;
    bit          t_o;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_row <= 0;
            m_err <= 1'b0;
            m_res <= '0;
            m_ovf <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (abort) begin
                m_cnt <= 0;
            end else if (m_cnt == 0) begin
                if (start) begin
                    if (int'(row_select) < NR) begin
                        ref_dot(int'(row_select), signed_mode, saturate, t_r, t_o);
                        m_pres <= t_r;
                        m_povf <= t_o;
                        m_row  <= int'(row_select);
                        m_cnt  <= 1;
                    end else begin
                        m_err <= 1'b1;
                    end
                end
            end else if (m_cnt == BEATS + 3) begin
                m_cnt <= 0;
            end else begin
                if (m_cnt == BEATS + 2) begin
                    m_res <= m_pres;
                    m_ovf <= m_povf;
                end
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin : cmp
        logic [L*PA_W-1:0] epa;
        logic [L*WA_W-1:0] ewa;
        bit iss;
        int k;
        iss = (m_cnt >= 1) && (m_cnt <= BEATS);
        k = m_cnt - 1;
        for (int i = 0; i < L; i++) begin
            epa[i*PA_W +: PA_W] = PA_W'(iss ? k*L + i : i);
            ewa[i*WA_W +: WA_W] = WA_W'(iss ? m_row*VL + k*L + i : i);
        end
        chk("busy", busy, (m_cnt >= 1) && (m_cnt <= BEATS + 2));
        chk("done", done, m_cnt == BEATS + 3);
        chk("err", err, m_err);
        chk("result", result, m_res);
        chk("overflow", overflow, m_ovf);
        chk("pixel_addr", pixel_addr, epa);
        chk("weight_addr", weight_addr, ewa);
    end

    task automatic fill_const(input logic [7:0] p, input logic [15:0] w);
        for (int j = 0; j < VL; j++) pix_mem[j] = p;
        for (int j = 0; j < NR*VL; j++) wt_mem[j] = w;
    endtask

    task automatic fill_rand(input int kind);
        for (int j = 0; j < VL; j++)
            pix_mem[j] = (kind == 2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        for (int j = 0; j < NR*VL; j++)
            wt_mem[j] = (kind == 1) ? 16'($urandom_range(0, 4) - 2) : 16'($urandom);
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int n = 0; n < 1000; n++) begin
            if (done === 1'b1) begin
                dc = cyc - t0 + 1;
                break;
            end
            @(negedge clk);
        end
        if (dc < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input int row, input bit sgn, input bit sat,
                       output int dc, output logic [L*WA_W-1:0] wa1);
        @(posedge clk); #1;
        row_select = RS_W'(row);
        signed_mode = sgn;
        saturate = sat;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        @(negedge clk);
        wa1 = weight_addr;
        wait_done(dc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int dc;
        logic [L*WA_W-1:0] wa1;
        logic [15:0] er, held;
        bit eo;
        int row;
        bit sg, sa;

        fill_const(8'd1, 16'd1);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_paddr_l1", pixel_addr[PA_W +: PA_W], 1);
        @(posedge clk); #1;
        rst = 1'b0;

        ref_dot(0, 0, 0, er, eo);
        chk("model_ones", er, 784);
        run(0, 0, 0, dc, wa1);
        chk("t1_done_cycle", dc, 395);
        chk("t1_result", result, 784);
        chk("t1_overflow", overflow, 0);

        fill_const(8'd2, 16'hFFFF);
        ref_dot(0, 1, 0, er, eo);
        chk("model_signed", er, 16'hF9E0);
        run(0, 1, 0, dc, wa1);
        chk("t2_result", result, 16'hF9E0);
        chk("t2_overflow", overflow, 0);

        fill_const(8'd255, 16'hFFFF);
        run(3, 0, 1, dc, wa1);
        chk("t3_sat_result", result, 16'hFFFF);
        chk("t3_sat_overflow", overflow, 1);
        run(3, 0, 0, dc, wa1);
        chk("t3_wrap_result", result, 16'hF310);
        chk("t3_wrap_overflow", overflow, 1);

        run(9, 0, 0, dc, wa1);
        chk("t4_waddr_l0", wa1[0 +: WA_W], 7056);
        chk("t4_waddr_l1", wa1[WA_W +: WA_W], 7057);

        @(posedge clk); #1;
        row_select = RS_W'(10);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t4_err_pulse", err, 1);
        chk("t4_err_busy", busy, 0);
        @(negedge clk);
        chk("t4_err_clear", err, 0);

        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_start_err", err, 0);
        chk("abort_start_busy", busy, 0);

        fill_rand(0);
        held = result;
        @(posedge clk); #1;
        row_select = RS_W'(2);
        signed_mode = 1'b1;
        saturate = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        repeat (100) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        row_select = RS_W'(4);
        signed_mode = 1'b0;
        saturate = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("t5_busy_low", busy, 0);
        chk("t5_no_done", done, 0);
        chk("t5_result_held", result, held);
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        wait_done(dc);
        ref_dot(4, 0, 1, er, eo);
        chk("t5_restart_cycle", dc, 395);
        chk("t5_restart_result", result, er);
        chk("t5_restart_ovf", overflow, eo);

        for (int it = 0; it < 6; it++) begin
            fill_rand(it % 3);
            row = $urandom_range(0, NR - 1);
            sg = 1'($urandom_range(0, 1));
            sa = 1'($urandom_range(0, 1));
            run(row, sg, sa, dc, wa1);
            ref_dot(row, sg, sa, er, eo);
            chk("rand_result", result, er);
            chk("rand_overflow", overflow, eo);
        end

        fill_rand(0);
        @(posedge clk); #1;
        row_select = RS_W'(5);
        signed_mode = 1'b1;
        saturate = 1'b1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        t0 = cyc;
        dc = n_done4;
        repeat (49) @(posedge clk);
        #1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        begin : w4
            int d4;
            d4 = -1;
            for (int n = 0; n < 1000; n++) begin
                @(negedge clk);
                if (done4 === 1'b1) begin
                    d4 = cyc - t0 + 1;
                    break;
                end
            end
            chk("t6_done_cycle", d4, 199);
        end
        ref_dot(5, 1, 1, er, eo);
        chk("t6_result", res4, er);
        chk("t6_overflow", ovf4, eo);
        repeat (10) @(negedge clk);
        chk("t6_single_done", n_done4 - dc, 1);
        chk("t6_busy_idle", busy4, 0);

        run(1, 0, 0, dc, wa1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_paddr_l0", pixel_addr[0 +: PA_W], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
